// File: rtl/branch_unit.sv
// ----------------------------------------------------------------------------
// branch_unit
//   Resolves branch requests from decode against the architectural compare
//   flags written back by the ALU. It produces the next PC and a taken
//   indication, and holds a fixed-length flush toward fetch/decode after a
//   taken branch.
//
// Ports
//   clk, rst_n                  clock; synchronous active-low reset
//   flag_we                     ALU finished a CMP; capture zero/less/greater
//   zero_in, less_in, greater_in  raw ALU flags
//   cmp_pending                 a CMP is still in flight upstream
//   br_valid / br_ready         request handshake from decode
//   br_op, br_pc, br_off        condition code, branch PC, signed offset
//   resolved                    one-cycle pulse; taken/next_pc valid with it
//   taken, next_pc              resolution result, held until the next one
//   flush                       squash younger instructions
//   zero_q, less_q, greater_q   architectural flag register
//
// Build option
//   FLAG_FORWARD_EN  when defined, a branch waiting on flags resolves in the
//                    same cycle the flags arrive, using the raw ALU flags.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | ready for a request (br_ready=1)
// S_WAIT_FLAGS | request captured, waiting for the in-flight CMP writeback
// S_RESOLVE    | resolved pulse visible, result presented on taken/next_pc
// S_FLUSH      | flush held high for FLUSH_CYCLES cycles
// ----------------------------------------------------------------------------
module branch_unit #(
   parameter int ADDR_WIDTH   = 16,
   parameter int BR_OP_BITS   = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flag_we,
   input  logic                  zero_in,
   input  logic                  less_in,
   input  logic                  greater_in,
   input  logic                  cmp_pending,
   input  logic                  br_valid,
   output logic                  br_ready,
   input  logic [BR_OP_BITS-1:0] br_op,
   input  logic [ADDR_WIDTH-1:0] br_pc,
   input  logic [ADDR_WIDTH-1:0] br_off,
   output logic                  resolved,
   output logic                  taken,
   output logic [ADDR_WIDTH-1:0] next_pc,
   output logic                  flush,
   output logic                  zero_q,
   output logic                  less_q,
   output logic                  greater_q
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   localparam logic [BR_OP_BITS-1:0] OP_JMP   = BR_OP_BITS'(0);
   localparam logic [BR_OP_BITS-1:0] OP_JE    = BR_OP_BITS'(1);
   localparam logic [BR_OP_BITS-1:0] OP_JNE   = BR_OP_BITS'(2);
   localparam logic [BR_OP_BITS-1:0] OP_JL    = BR_OP_BITS'(3);
   localparam logic [BR_OP_BITS-1:0] OP_JLE   = BR_OP_BITS'(4);
   localparam logic [BR_OP_BITS-1:0] OP_JG    = BR_OP_BITS'(5);
   localparam logic [BR_OP_BITS-1:0] OP_JGE   = BR_OP_BITS'(6);
   localparam logic [BR_OP_BITS-1:0] OP_NEVER = BR_OP_BITS'(7);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_FLAGS,
      S_RESOLVE,
      S_FLUSH
   } state_t;

   state_t                state_q;
   logic [BR_OP_BITS-1:0] op_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] off_q;
   logic                  resolved_q;
   logic                  taken_q;
   logic [ADDR_WIDTH-1:0] next_pc_q;
   logic                  flush_q;
   logic [CNT_W-1:0]      cnt_q;

   function automatic logic cond_met(input logic [BR_OP_BITS-1:0] op,
                                     input logic z, input logic l, input logic g);
      logic c;
      c = 1'b0;
      case (op)
         OP_JMP:   c = 1'b1;
         OP_JE:    c = z;
         OP_JNE:   c = !z;
         OP_JL:    c = l;
         OP_JLE:   c = l | z;
         OP_JG:    c = g;
         OP_JGE:   c = g | z;
         OP_NEVER: c = 1'b0;
         default:  c = 1'b0;
      endcase
      return c;
   endfunction

   logic                  hs;
   logic                  zero_d, less_d, greater_d;
   logic [BR_OP_BITS-1:0] sel_op;
   logic [ADDR_WIDTH-1:0] sel_pc, sel_off;
   logic                  needs_flags_d;
   logic                  cond_d;
   logic [ADDR_WIDTH-1:0] next_pc_d;

   assign br_ready = (state_q == S_IDLE);
   assign hs       = br_valid && br_ready;

   // Flags as they will be in the register after this edge; a CMP writeback
   // coincident with the handshake must be seen by that branch.
   assign zero_d    = flag_we ? zero_in    : zero_q;
   assign less_d    = flag_we ? less_in    : less_q;
   assign greater_d = flag_we ? greater_in : greater_q;

   // In IDLE the request is still on the inputs; afterwards it is captured.
   assign sel_op  = (state_q == S_IDLE) ? br_op  : op_q;
   assign sel_pc  = (state_q == S_IDLE) ? br_pc  : pc_q;
   assign sel_off = (state_q == S_IDLE) ? br_off : off_q;

   assign needs_flags_d = (sel_op >= OP_JE) && (sel_op <= OP_JGE);
   assign cond_d        = cond_met(sel_op, zero_d, less_d, greater_d);
   assign next_pc_d     = cond_d ? (sel_pc + sel_off) : (sel_pc + ADDR_WIDTH'(1));

   // taken/next_pc are computed on the edge that enters RESOLVE so they are
   // valid together with the resolved pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         zero_q     <= 1'b0;
         less_q     <= 1'b0;
         greater_q  <= 1'b0;
         op_q       <= '0;
         pc_q       <= '0;
         off_q      <= '0;
         resolved_q <= 1'b0;
         taken_q    <= 1'b0;
         next_pc_q  <= '0;
         flush_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         resolved_q <= 1'b0;
         if (flag_we) begin
            zero_q    <= zero_in;
            less_q    <= less_in;
            greater_q <= greater_in;
         end
         case (state_q)
            S_IDLE: begin
               if (hs) begin
                  op_q  <= br_op;
                  pc_q  <= br_pc;
                  off_q <= br_off;
                  if (needs_flags_d && cmp_pending && !flag_we) begin
                     state_q <= S_WAIT_FLAGS;
                  end else begin
                     state_q    <= S_RESOLVE;
                     resolved_q <= 1'b1;
                     taken_q    <= cond_d;
                     next_pc_q  <= next_pc_d;
                  end
               end
            end
            S_WAIT_FLAGS: begin
               if (flag_we) begin
                  taken_q   <= cond_d;
                  next_pc_q <= next_pc_d;
`ifdef FLAG_FORWARD_EN
                  // Resolution already presented combinationally this cycle.
                  if (cond_d) begin
                     state_q <= S_FLUSH;
                     flush_q <= 1'b1;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     state_q <= S_IDLE;
                  end
`else
                  state_q    <= S_RESOLVE;
                  resolved_q <= 1'b1;
`endif
               end
            end
            S_RESOLVE: begin
               if (taken_q) begin
                  state_q <= S_FLUSH;
                  flush_q <= 1'b1;
                  cnt_q   <= CNT_LOAD;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_FLUSH: begin
               if (cnt_q == '0) begin
                  flush_q <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef FLAG_FORWARD_EN
   logic fwd;
   assign fwd      = (state_q == S_WAIT_FLAGS) && flag_we;
   assign resolved = resolved_q | fwd;
   assign taken    = fwd ? cond_d    : taken_q;
   assign next_pc  = fwd ? next_pc_d : next_pc_q;
`else
   assign resolved = resolved_q;
   assign taken    = taken_q;
   assign next_pc  = next_pc_q;
`endif
   assign flush = flush_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
   localparam int AW = 16;
   localparam int NF = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flag_we = 1'b0;
   logic          zero_in = 1'b0, less_in = 1'b0, greater_in = 1'b0;
   logic          cmp_pending = 1'b0;
   logic          br_valid = 1'b0;
   logic          br_ready;
   logic [2:0]    br_op = '0;
   logic [AW-1:0] br_pc = '0, br_off = '0;
   logic          resolved, taken, flush;
   logic [AW-1:0] next_pc;
   logic          zero_q, less_q, greater_q;

   int checks = 0;
   int errors = 0;
   bit m_z = 0, m_l = 0, m_g = 0;

   always #5 clk = ~clk;

   branch_unit #(.ADDR_WIDTH(AW), .BR_OP_BITS(3), .FLUSH_CYCLES(NF)) dut (
      .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
      .zero_in(zero_in), .less_in(less_in), .greater_in(greater_in),
      .cmp_pending(cmp_pending), .br_valid(br_valid), .br_ready(br_ready),
      .br_op(br_op), .br_pc(br_pc), .br_off(br_off),
      .resolved(resolved), .taken(taken), .next_pc(next_pc), .flush(flush),
      .zero_q(zero_q), .less_q(less_q), .greater_q(greater_q)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: condition table and PC arithmetic straight from the rules.
   function automatic bit model_taken(int op, bit z, bit l, bit g);
      case (op)
         0: return 1'b1;
         1: return z;
         2: return !z;
         3: return l;
         4: return l || z;
         5: return g;
         6: return g || z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [AW-1:0] model_npc(int pc, int off, bit t);
      int v;
      v = t ? (pc + off) % 65536 : (pc + 1) % 65536;
      return v[AW-1:0];
   endfunction

   task automatic write_flags(bit z, bit l, bit g);
      flag_we = 1'b1; zero_in = z; less_in = l; greater_in = g;
      m_z = z; m_l = l; m_g = g;
      tick();
      flag_we = 1'b0;
   endtask

   task automatic test_reset();
      logic [22:0] obs;
      rst_n = 1'b0;
      tick(); tick();
      obs = {br_ready, resolved, taken, flush, next_pc, zero_q, less_q, greater_q};
      checks++;
      if (obs !== {1'b1, 22'h0}) begin
         errors++; $display("FAIL reset_init got=%h exp=%h", obs, {1'b1, 22'h0});
      end
      rst_n = 1'b1;
      write_flags(1, 1, 1);
      checks++;
      if ({zero_q, less_q, greater_q} !== 3'b111) begin
         errors++; $display("FAIL flag_load got=%b exp=111", {zero_q, less_q, greater_q});
      end
      br_valid = 1'b1; br_op = 3'd0; br_pc = 16'h0005; br_off = 16'h0003;
      tick();
      br_valid = 1'b0;
      tick();
      checks++;
      if (flush !== 1'b1) begin
         errors++; $display("FAIL pre_reset_flush got=%b exp=1", flush);
      end
      rst_n = 1'b0;
      tick(); tick();
      m_z = 0; m_l = 0; m_g = 0;
      obs = {br_ready, resolved, taken, flush, next_pc, zero_q, less_q, greater_q};
      checks++;
      if (obs !== {1'b1, 22'h0}) begin
         errors++; $display("FAIL reset_in_flush got=%h exp=%h", obs, {1'b1, 22'h0});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({br_ready, flush, resolved} !== 3'b100) begin
         errors++; $display("FAIL post_reset_idle got=%b exp=100", {br_ready, flush, resolved});
      end
   endtask

   task automatic test_je_taken();
      write_flags(1, 0, 0);
      br_valid = 1'b1; br_op = 3'd1; br_pc = 16'h0010; br_off = 16'h0004;
      tick();
      br_valid = 1'b0;
      checks++;
      if ({resolved, taken, next_pc, flush} !== {1'b1, 1'b1, 16'h0014, 1'b0}) begin
         errors++; $display("FAIL je_resolve got=%b%b_%h_%b exp=11_0014_0", resolved, taken, next_pc, flush);
      end
      tick();
      checks++;
      if ({resolved, flush, br_ready, taken, next_pc} !== {3'b010, 1'b1, 16'h0014}) begin
         errors++; $display("FAIL je_flush1 got=%b%b%b exp=010", resolved, flush, br_ready);
      end
      tick();
      checks++;
      if ({flush, br_ready} !== 2'b10) begin
         errors++; $display("FAIL je_flush2 got=%b exp=10", {flush, br_ready});
      end
      tick();
      checks++;
      if ({flush, br_ready} !== 2'b01) begin
         errors++; $display("FAIL je_flush_end got=%b exp=01", {flush, br_ready});
      end
   endtask

   task automatic test_jg_not_taken();
      write_flags(0, 1, 0);
      br_valid = 1'b1; br_op = 3'd5; br_pc = 16'h0020; br_off = 16'h0100;
      tick();
      br_valid = 1'b0;
      checks++;
      if ({resolved, taken, next_pc} !== {1'b1, 1'b0, 16'h0021}) begin
         errors++; $display("FAIL jg_resolve got=%b%b_%h exp=10_0021", resolved, taken, next_pc);
      end
      tick();
      checks++;
      if ({resolved, flush, br_ready} !== 3'b001) begin
         errors++; $display("FAIL jg_ready got=%b exp=001", {resolved, flush, br_ready});
      end
   endtask

   task automatic test_wait_flags();
      write_flags(0, 0, 0);
      br_valid = 1'b1; br_op = 3'd3; br_pc = 16'h0040; br_off = 16'h0010; cmp_pending = 1'b1;
      tick();
      br_valid = 1'b0; cmp_pending = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({resolved, br_ready} !== 2'b00) begin
            errors++; $display("FAIL wait_hold%0d got=%b exp=00", i, {resolved, br_ready});
         end
         tick();
      end
      flag_we = 1'b1; zero_in = 1'b0; less_in = 1'b1; greater_in = 1'b0;
      m_z = 0; m_l = 1; m_g = 0;
`ifdef FLAG_FORWARD_EN
      #1;
      checks++;
      if ({resolved, taken, next_pc} !== {1'b1, 1'b1, 16'h0050}) begin
         errors++; $display("FAIL wait_fwd_resolve got=%b%b_%h exp=11_0050", resolved, taken, next_pc);
      end
      tick();
      flag_we = 1'b0;
`else
      #1;
      checks++;
      if (resolved !== 1'b0) begin
         errors++; $display("FAIL wait_early_resolve got=%b exp=0", resolved);
      end
      tick();
      flag_we = 1'b0;
      checks++;
      if ({resolved, taken, next_pc} !== {1'b1, 1'b1, 16'h0050}) begin
         errors++; $display("FAIL wait_resolve got=%b%b_%h exp=11_0050", resolved, taken, next_pc);
      end
      tick();
`endif
      checks++;
      if ({resolved, flush} !== 2'b01) begin
         errors++; $display("FAIL wait_flush got=%b exp=01", {resolved, flush});
      end
      for (int i = 0; i < NF; i++) tick();
      checks++;
      if ({flush, br_ready} !== 2'b01) begin
         errors++; $display("FAIL wait_idle got=%b exp=01", {flush, br_ready});
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] pcs [2] = '{16'hFFFE, 16'h0010};
      logic [AW-1:0] offs[2] = '{16'h0004, 16'hFFF0};
      logic [AW-1:0] exps[2] = '{16'h0002, 16'h0000};
      for (int i = 0; i < 2; i++) begin
         br_valid = 1'b1; br_op = 3'd0; br_pc = pcs[i]; br_off = offs[i];
         tick();
         br_valid = 1'b0;
         checks++;
         if ({resolved, taken, next_pc} !== {2'b11, exps[i]}) begin
            errors++; $display("FAIL wrap%0d got=%b%b_%h exp=11_%h", i, resolved, taken, next_pc, exps[i]);
         end
         repeat (NF + 1) tick();
         checks++;
         if (br_ready !== 1'b1) begin
            errors++; $display("FAIL wrap%0d_ready got=%b exp=1", i, br_ready);
         end
      end
   endtask

   task automatic test_hold_during_flush();
      br_valid = 1'b1; br_op = 3'd0; br_pc = 16'h0100; br_off = 16'h0020;
      tick();
      br_op = 3'd7; br_pc = 16'h0200; br_off = 16'h0008;
      checks++;
      if ({resolved, taken, next_pc} !== {2'b11, 16'h0120}) begin
         errors++; $display("FAIL hold_first got=%b%b_%h exp=11_0120", resolved, taken, next_pc);
      end
      for (int i = 0; i < NF; i++) begin
         tick();
         checks++;
         if ({flush, br_ready, resolved} !== 3'b100) begin
            errors++; $display("FAIL hold_flush%0d got=%b exp=100", i, {flush, br_ready, resolved});
         end
      end
      tick();
      checks++;
      if ({flush, br_ready, resolved} !== 3'b010) begin
         errors++; $display("FAIL hold_idle got=%b exp=010", {flush, br_ready, resolved});
      end
      tick();
      br_valid = 1'b0;
      checks++;
      if ({resolved, taken, next_pc} !== {2'b10, 16'h0201}) begin
         errors++; $display("FAIL never_resolve got=%b%b_%h exp=10_0201", resolved, taken, next_pc);
      end
      tick();
      checks++;
      if ({flush, br_ready} !== 2'b01) begin
         errors++; $display("FAIL never_noflush got=%b exp=01", {flush, br_ready});
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] pc;
      write_flags(1, 0, 0);
      br_valid = 1'b1; br_op = 3'd2;
      for (int i = 0; i < 3; i++) begin
         pc = AW'(16'h0300 + 4 * i);
         br_pc = pc; br_off = 16'h0040;
         tick();
         br_pc = pc + 16'h0004;
         checks++;
         if ({resolved, taken, next_pc} !== {2'b10, pc + 16'h0001}) begin
            errors++; $display("FAIL b2b%0d_resolve got=%b%b_%h exp=10_%h", i, resolved, taken, next_pc, pc + 16'h0001);
         end
         tick();
         checks++;
         if ({resolved, br_ready, flush} !== 3'b010) begin
            errors++; $display("FAIL b2b%0d_ready got=%b exp=010", i, {resolved, br_ready, flush});
         end
      end
      br_valid = 1'b0;
   endtask

   task automatic test_random();
      int op, pc, off, dly;
      bit pend, hs_we, waits, exp_t;
      logic [AW-1:0] exp_pc;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1)
            write_flags(1'($urandom), 1'($urandom), 1'($urandom));
         op = $urandom_range(0, 7); pc = $urandom_range(0, 65535); off = $urandom_range(0, 65535);
         pend = 1'($urandom_range(0, 1)); hs_we = ($urandom_range(0, 3) == 0); dly = $urandom_range(0, 3);
         br_valid = 1'b1; br_op = 3'(op); br_pc = AW'(pc); br_off = AW'(off); cmp_pending = pend;
         if (hs_we) begin
            flag_we = 1'b1; zero_in = 1'($urandom); less_in = 1'($urandom); greater_in = 1'($urandom);
            m_z = zero_in; m_l = less_in; m_g = greater_in;
         end
         waits = (op >= 1) && (op <= 6) && pend && !hs_we;
         tick();
         br_valid = 1'b0; flag_we = 1'b0; cmp_pending = 1'b0;
         zero_in = 1'($urandom); less_in = 1'($urandom); greater_in = 1'($urandom);
         if (waits) begin
            for (int d = 0; d < dly; d++) begin
               checks++;
               if ({resolved, br_ready} !== 2'b00) begin
                  errors++; $display("FAIL rnd%0d_wait got=%b exp=00", n, {resolved, br_ready});
               end
               tick();
            end
            flag_we = 1'b1; zero_in = 1'($urandom); less_in = 1'($urandom); greater_in = 1'($urandom);
            m_z = zero_in; m_l = less_in; m_g = greater_in;
            exp_t = model_taken(op, m_z, m_l, m_g);
            exp_pc = model_npc(pc, off, exp_t);
`ifdef FLAG_FORWARD_EN
            #1;
            checks++;
            if ({resolved, taken, next_pc} !== {1'b1, exp_t, exp_pc}) begin
               errors++; $display("FAIL rnd%0d_fwd got=%b%b_%h exp=1%b_%h", n, resolved, taken, next_pc, exp_t, exp_pc);
            end
            tick();
            flag_we = 1'b0;
`else
            tick();
            flag_we = 1'b0;
            checks++;
            if ({resolved, taken, next_pc} !== {1'b1, exp_t, exp_pc}) begin
               errors++; $display("FAIL rnd%0d_resolve got=%b%b_%h exp=1%b_%h", n, resolved, taken, next_pc, exp_t, exp_pc);
            end
            tick();
`endif
         end else begin
            exp_t = model_taken(op, m_z, m_l, m_g);
            exp_pc = model_npc(pc, off, exp_t);
            checks++;
            if ({resolved, taken, next_pc} !== {1'b1, exp_t, exp_pc}) begin
               errors++; $display("FAIL rnd%0d_resolve got=%b%b_%h exp=1%b_%h", n, resolved, taken, next_pc, exp_t, exp_pc);
            end
            tick();
         end
         checks++;
         if ({resolved, taken, next_pc, zero_q, less_q, greater_q} !== {1'b0, exp_t, exp_pc, m_z, m_l, m_g}) begin
            errors++; $display("FAIL rnd%0d_hold got=%b%b_%h_%b%b%b exp=0%b_%h_%b%b%b", n, resolved, taken, next_pc,
                               zero_q, less_q, greater_q, exp_t, exp_pc, m_z, m_l, m_g);
         end
         if (exp_t) begin
            for (int i = 0; i < NF; i++) begin
               checks++;
               if ({flush, br_ready} !== 2'b10) begin
                  errors++; $display("FAIL rnd%0d_flush%0d got=%b exp=10", n, i, {flush, br_ready});
               end
               tick();
            end
         end
         checks++;
         if ({flush, br_ready} !== 2'b01) begin
            errors++; $display("FAIL rnd%0d_idle got=%b exp=01", n, {flush, br_ready});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_je_taken();
      test_jg_not_taken();
      test_wait_flags();
      test_wrap();
      test_hold_during_flush();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
